// File: rtl/arb_pkg.sv
// Arbiter state encoding and the latched grant record.
package arb_pkg;
    localparam int MAX_CPUS = 16;
    localparam int CORE_W   = $clog2(MAX_CPUS);

    localparam logic CLS_I = 1'b0;
    localparam logic CLS_D = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, LOCK} arb_state_t;

    typedef struct packed {
        logic              cls;
        logic [CORE_W-1:0] core;
    } grant_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: the machine word and the RAM handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: lowest-index requester strictly after `last`, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic [CPUS-1:0]   req,
    input  logic [CORE_W-1:0] last,
    output logic              valid,
    output logic [CORE_W-1:0] idx
);
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Wrapped candidates first, then those after `last` override them.
        for (int c = CPUS-1; c >= 0; c--) begin
            if (req[c] && (CORE_W'(c) <= last)) begin
                valid = 1'b1;
                idx   = CORE_W'(c);
            end
        end
        for (int c = CPUS-1; c >= 0; c--) begin
            if (req[c] && (CORE_W'(c) > last)) begin
                valid = 1'b1;
                idx   = CORE_W'(c);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Cache-to-RAM arbiter: data before instruction, round-robin per class.
// Optional BLOCK_LOCK_EN keeps the grant for the second word of a block.
module mem_arbiter
    import cpu_types_pkg::*;
    import arb_pkg::*;
#(
    parameter int CPUS      = 2,
    parameter int LOCK_WAIT = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  word_t [CPUS-1:0]      iaddr,
    output logic [CPUS-1:0]       iwait,
    output word_t [CPUS-1:0]      iload,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  word_t [CPUS-1:0]      daddr,
    input  word_t [CPUS-1:0]      dstore,
    output logic [CPUS-1:0]       dwait,
    output word_t [CPUS-1:0]      dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output word_t                 ramaddr,
    output word_t                 ramstore,
    input  word_t                 ramload,
    input  ramstate_t             ramstate
);
    arb_state_t        state, state_n;
    grant_t            grant, grant_n;
    logic [CORE_W-1:0] last_d, last_d_n, last_i, last_i_n;

    logic [CPUS-1:0]   d_req;
    logic              d_vld, i_vld;
    logic [CORE_W-1:0] d_idx, i_idx;

    assign d_req = dREN | dWEN;

    rr_pick #(.CPUS(CPUS)) u_dpick (.req(d_req), .last(last_d), .valid(d_vld), .idx(d_idx));
    rr_pick #(.CPUS(CPUS)) u_ipick (.req(iREN),  .last(last_i), .valid(i_vld), .idx(i_idx));

    for (genvar c = 0; c < CPUS; c++) begin : g_load
        assign iload[c] = ramload;
        assign dload[c] = ramload;
    end

    // Signals of the currently granted core
    logic            g_dreq, g_wr, g_ireq, g_live;
    logic [CPUS-1:0] g_sel;
    word_t           g_daddr, g_iaddr, g_store;

    always_comb begin
        g_dreq  = 1'b0;
        g_wr    = 1'b0;
        g_ireq  = 1'b0;
        g_sel   = '0;
        g_daddr = '0;
        g_iaddr = '0;
        g_store = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (grant.core == CORE_W'(c)) begin
                g_dreq   = d_req[c];
                g_wr     = dWEN[c];
                g_ireq   = iREN[c];
                g_sel[c] = 1'b1;
                g_daddr  = daddr[c];
                g_iaddr  = iaddr[c];
                g_store  = dstore[c];
            end
        end
    end

    assign g_live = (grant.cls == CLS_D) ? g_dreq : g_ireq;

`ifdef BLOCK_LOCK_EN
    localparam logic [7:0] LW_LAST = 8'(LOCK_WAIT - 1);
    word_t      lock_addr, lock_addr_n;
    logic [7:0] lock_cnt, lock_cnt_n;
`endif

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_d_n = last_d;
        last_i_n = last_i;
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
`ifdef BLOCK_LOCK_EN
        lock_addr_n = lock_addr;
        lock_cnt_n  = lock_cnt;
`endif
        case (state)
            IDLE: begin
                if (d_vld) begin
                    grant_n = '{cls: CLS_D, core: d_idx};
                    state_n = REQ;
                end else if (i_vld) begin
                    grant_n = '{cls: CLS_I, core: i_idx};
                    state_n = REQ;
                end
            end
            REQ: begin
                ramaddr  = (grant.cls == CLS_D) ? g_daddr : g_iaddr;
                ramWEN   = g_live & (grant.cls == CLS_D) & g_wr;
                ramREN   = g_live & ~((grant.cls == CLS_D) & g_wr);
                ramstore = g_store;
                if (!g_live) begin
                    state_n = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_n = IDLE;
                    if (grant.cls == CLS_D) begin
                        dwait    = ~g_sel;
                        last_d_n = grant.core;
`ifdef BLOCK_LOCK_EN
                        if (!g_daddr[2]) begin
                            state_n     = LOCK;
                            lock_addr_n = g_daddr | 32'h4;
                            lock_cnt_n  = '0;
                        end
`endif
                    end else begin
                        iwait    = ~g_sel;
                        last_i_n = grant.core;
                    end
                end
            end
`ifdef BLOCK_LOCK_EN
            LOCK: begin
                // A request from the locked core at any other address ends the lock early.
                if (g_dreq && (g_daddr == lock_addr)) begin
                    state_n = REQ;
                end else if (g_dreq || (lock_cnt == LW_LAST)) begin
                    state_n = IDLE;
                end else begin
                    lock_cnt_n = lock_cnt + 8'd1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            grant  <= '0;
            last_d <= CORE_W'(CPUS - 1);
            last_i <= CORE_W'(CPUS - 1);
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            last_d <= last_d_n;
            last_i <= last_i_n;
        end
    end

`ifdef BLOCK_LOCK_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lock_addr <= '0;
            lock_cnt  <= '0;
        end else begin
            lock_addr <= lock_addr_n;
            lock_cnt  <= lock_cnt_n;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (CPUS=2), plus reset and lock sequences.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam word_t C0 = 32'hCAFE0000;  // dstore[0], constant throughout

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  iREN = '0, dREN = '0, dWEN = '0;
    word_t [1:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    word_t [1:0] iload, dload;
    logic        ramREN, ramWEN;
    word_t       ramaddr, ramstore;
    word_t       ramload = '0;
    ramstate_t   ramstate = FREE;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.CPUS(2), .LOCK_WAIT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] iren, dren, dwen;
        word_t      ia0, da0, da1, ds1;
        ramstate_t  rs;
        word_t      rl;
        logic [1:0] eiw, edw;
        logic       eren, ewen;
        word_t      eaddr, estore;
    } vec_t;

    function automatic vec_t mk(logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen,
                                word_t ia0, word_t da0, word_t da1, word_t ds1,
                                ramstate_t rs, word_t rl,
                                logic [1:0] eiw, logic [1:0] edw, logic eren, logic ewen,
                                word_t eaddr, word_t estore);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.ia0 = ia0; v.da0 = da0; v.da1 = da1; v.ds1 = ds1;
        v.rs = rs; v.rl = rl;
        v.eiw = eiw; v.edw = edw; v.eren = eren; v.ewen = ewen;
        v.eaddr = eaddr; v.estore = estore;
        return v;
    endfunction

    task automatic chk(string nm, logic [95:0] got, logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic logic [95:0] outs();
        return {26'd0, iwait, dwait, ramREN, ramWEN, ramaddr, ramstore};
    endfunction

    function automatic logic [95:0] pack(logic [1:0] iw, logic [1:0] dw, logic ren, logic wen,
                                         word_t a, word_t s);
        return {26'd0, iw, dw, ren, wen, a, s};
    endfunction

    task automatic apply(vec_t v);
        iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
        iaddr[0] = v.ia0; iaddr[1] = 32'h200;
        daddr[0] = v.da0; daddr[1] = v.da1;
        dstore[0] = C0; dstore[1] = v.ds1;
        ramstate = v.rs; ramload = v.rl;
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        iaddr = '0; daddr = '0; dstore = '0;
        idle = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, FREE, 0, 2'b11, 2'b11, 0, 0, 0, 0);

        // Data read with two BUSY cycles
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 0, 32'h40, 0, 0, FREE,   0,            2'b11, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 0, 32'h40, 0, 0, BUSY,   0,            2'b11, 2'b11, 1, 0, 32'h40, C0));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 0, 32'h40, 0, 0, BUSY,   0,            2'b11, 2'b11, 1, 0, 32'h40, C0));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 0, 32'h40, 0, 0, ACCESS, 32'hDEADBEEF, 2'b11, 2'b10, 1, 0, 32'h40, C0));
        tbl.push_back(idle);
        // Class priority: dcache of core 1 beats icache of core 0
        tbl.push_back(mk(2'b01, 2'b10, 2'b00, 0, 0, 32'h100, 0, FREE,   0,            2'b11, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 2'b10, 2'b00, 0, 0, 32'h100, 0, ACCESS, 32'h5555AAAA, 2'b11, 2'b01, 1, 0, 32'h100, 0));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 0, 0, 32'h100, 0, FREE,   0,            2'b11, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 0, 0, 32'h100, 0, ACCESS, 32'h11111111, 2'b10, 2'b11, 1, 0, 32'h0, C0));
        tbl.push_back(idle);
        // Round-robin, both data requests held: 0,1,0,1 with one IDLE bubble each
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(2'b00, 2'b11, 2'b00, 0, 32'h40, 32'h100, 0, FREE, 0, 2'b11, 2'b11, 0, 0, 0, 0));
            if (k % 2 == 0)
                tbl.push_back(mk(2'b00, 2'b11, 2'b00, 0, 32'h40, 32'h100, 0, ACCESS, word_t'(k + 1),
                                 2'b11, 2'b10, 1, 0, 32'h40, C0));
            else
                tbl.push_back(mk(2'b00, 2'b11, 2'b00, 0, 32'h40, 32'h100, 0, ACCESS, word_t'(k + 1),
                                 2'b11, 2'b01, 1, 0, 32'h100, 0));
        end
        tbl.push_back(idle);
        // Write: dREN and dWEN both set is a write
        tbl.push_back(mk(2'b00, 2'b10, 2'b10, 0, 0, 32'h80, 32'h12345678, FREE,   0, 2'b11, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 2'b10, 2'b10, 0, 0, 32'h80, 32'h12345678, ACCESS, 0, 2'b11, 2'b01, 0, 1, 32'h80, 32'h12345678));
        tbl.push_back(idle);
        // Abort after one BUSY: no pulse, pointer stays at 1 so core 0 wins next
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 0, 32'h40, 0, 0, FREE, 0, 2'b11, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 0, 32'h40, 0, 0, BUSY, 0, 2'b11, 2'b11, 1, 0, 32'h40, C0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 32'h40, 0, 0, BUSY, 0, 2'b11, 2'b11, 0, 0, 32'h40, C0));
        tbl.push_back(idle);
        tbl.push_back(mk(2'b00, 2'b11, 2'b00, 0, 32'h40, 32'h100, 0, FREE,   0,     2'b11, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 2'b11, 2'b00, 0, 32'h40, 32'h100, 0, ACCESS, 32'h77, 2'b11, 2'b10, 1, 0, 32'h40, C0));
        // ERROR x3 then ACCESS: a single wait pulse
        tbl.push_back(mk(2'b00, 2'b10, 2'b00, 0, 0, 32'h100, 0, FREE, 0, 2'b11, 2'b11, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(2'b00, 2'b10, 2'b00, 0, 0, 32'h100, 0, ERROR, 0, 2'b11, 2'b11, 1, 0, 32'h100, 0));
        tbl.push_back(mk(2'b00, 2'b10, 2'b00, 0, 0, 32'h100, 0, ACCESS, 32'h99, 2'b11, 2'b01, 1, 0, 32'h100, 0));
        tbl.push_back(idle);

        apply(idle);
        #2;
        chk("reset_outputs", outs(), pack(2'b11, 2'b11, 0, 0, 0, 0));
        repeat (2) @(posedge CLK);
        #3 nRST = 1'b1;

`ifndef BLOCK_LOCK_EN
        foreach (tbl[r]) begin
            @(posedge CLK); #1;
            apply(tbl[r]);
            @(negedge CLK);
            chk($sformatf("row%0d", r), outs(),
                pack(tbl[r].eiw, tbl[r].edw, tbl[r].eren, tbl[r].ewen, tbl[r].eaddr, tbl[r].estore));
            if (tbl[r].edw[0] == 1'b0) chk($sformatf("row%0d_dload0", r), 96'(dload[0]), 96'(tbl[r].rl));
            if (tbl[r].edw[1] == 1'b0) chk($sformatf("row%0d_dload1", r), 96'(dload[1]), 96'(tbl[r].rl));
            if (tbl[r].eiw[0] == 1'b0) chk($sformatf("row%0d_iload0", r), 96'(iload[0]), 96'(tbl[r].rl));
        end
`else
        // Block lock: core 0 reads 0x40 then 0x44 ahead of pending core 1
        @(posedge CLK); #1;
        apply(mk(2'b00, 2'b11, 2'b00, 0, 32'h40, 32'h100, 0, FREE, 0, 2'b11, 2'b11, 0, 0, 0, 0));
        @(negedge CLK);
        chk("lock_idle", outs(), pack(2'b11, 2'b11, 0, 0, 0, 0));
        @(posedge CLK); #1;
        ramstate = ACCESS; ramload = 32'hA0A0A0A0;
        @(negedge CLK);
        chk("lock_first", outs(), pack(2'b11, 2'b10, 1, 0, 32'h40, C0));
        @(posedge CLK); #1;
        daddr[0] = 32'h44; ramstate = FREE;
        @(negedge CLK);
        chk("lock_wait", outs(), pack(2'b11, 2'b11, 0, 0, 0, 0));
        @(posedge CLK); #1;
        ramstate = ACCESS;
        @(negedge CLK);
        chk("lock_second", outs(), pack(2'b11, 2'b10, 1, 0, 32'h44, C0));
        @(posedge CLK); #1;
        apply(idle);
        repeat (3) @(posedge CLK);
`endif

        // Reset asserted mid-REQ
        @(posedge CLK); #1;
        apply(mk(2'b00, 2'b01, 2'b00, 0, 32'h40, 0, 0, BUSY, 0, 2'b11, 2'b11, 0, 0, 0, 0));
        @(posedge CLK); #1;
        chk("pre_reset_req", outs(), pack(2'b11, 2'b11, 1, 0, 32'h40, C0));
        nRST = 1'b0;
        #1;
        chk("reset_mid_req", outs(), pack(2'b11, 2'b11, 0, 0, 0, 0));
        @(posedge CLK); #1;
        ramstate = ACCESS;
        @(negedge CLK);
        chk("reset_held", outs(), pack(2'b11, 2'b11, 0, 0, 0, 0));
        #2 nRST = 1'b1;
        @(posedge CLK); #1;
        ramstate = FREE;
        @(negedge CLK);
        chk("post_reset_grant", outs(), pack(2'b11, 2'b11, 1, 0, 32'h40, C0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
